// File: rtl/traffic_light_ctrl_n.sv
// N-direction traffic light controller with sensor-driven
// round-robin right-of-way and a night-flash mode.
module traffic_light_ctrl_n #(
  parameter int N_DIR     = 4,
  parameter int GREEN_MIN = 4,
  parameter int GREEN_MAX = 10,
  parameter int YELLOW_T  = 2,
  parameter int ALLRED_T  = 1,
  parameter int FLASH_T   = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_DIR-1:0]         sensor,
  input  logic                     flash_en,
  output logic [N_DIR-1:0]         green,
  output logic [N_DIR-1:0]         yellow,
  output logic [N_DIR-1:0]         red,
  output logic [$clog2(N_DIR)-1:0] cur_dir,
  output logic [1:0]               state
);

  localparam int DW = $clog2(N_DIR);
  localparam int TW = 16;

  typedef enum logic [1:0] {
    S_GREEN  = 2'd0,
    S_YELLOW = 2'd1,
    S_ALLRED = 2'd2,
    S_FLASH  = 2'd3
  } state_e;

  localparam logic [N_DIR-1:0] ONE =
    {{(N_DIR-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [DW-1:0]    dir_q, dir_d, dir_nxt;
  logic [TW-1:0]    timer_q, timer_d;
  logic             phase_q, phase_d;
  logic [N_DIR-1:0] green_q, green_d;
  logic [N_DIR-1:0] yellow_q, yellow_d;
  logic [N_DIR-1:0] red_q, red_d;
  logic [N_DIR-1:0] own, own_d;
  logic             others;
  logic             found;

  assign own    = ONE << dir_q;
  assign others = |(sensor & ~own);

  // First requester after dir_q (wrapping), else dir_q+1.
  always_comb begin
    dir_nxt = DW'((int'(dir_q) + 1) % N_DIR);
    found   = 1'b0;
    for (int k = 1; k < N_DIR; k++) begin
      if (!found && sensor[(int'(dir_q) + k) % N_DIR]) begin
        dir_nxt = DW'((int'(dir_q) + k) % N_DIR);
        found   = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    timer_d = timer_q + TW'(1);
    phase_d = phase_q;
    if (flash_en) begin
      if (state_q != S_FLASH) begin
        state_d = S_FLASH;
        timer_d = '0;
        phase_d = 1'b0;
      end else if (timer_q == TW'(FLASH_T - 1)) begin
        timer_d = '0;
        phase_d = ~phase_q;
      end
    end else begin
      unique case (state_q)
        S_GREEN: begin
          if (others &&
              ((timer_q >= TW'(GREEN_MIN - 1) && !sensor[dir_q]) ||
               timer_q >= TW'(GREEN_MAX - 1))) begin
            state_d = S_YELLOW;
            timer_d = '0;
          end else if (timer_q >= TW'(GREEN_MAX - 1)) begin
            timer_d = TW'(GREEN_MAX - 1);
          end
        end
        S_YELLOW: begin
          if (timer_q == TW'(YELLOW_T - 1)) begin
            state_d = S_ALLRED;
            timer_d = '0;
          end
        end
        S_ALLRED: begin
          if (timer_q == TW'(ALLRED_T - 1)) begin
            state_d = S_GREEN;
            dir_d   = dir_nxt;
            timer_d = '0;
          end
        end
        S_FLASH: begin
          state_d = S_ALLRED;
          timer_d = '0;
        end
      endcase
    end
  end

  // Lamps decode from next-state so they line up with state_q.
  assign own_d = ONE << dir_d;

  always_comb begin
    green_d  = '0;
    yellow_d = '0;
    red_d    = '1;
    unique case (state_d)
      S_GREEN: begin
        green_d = own_d;
        red_d   = ~own_d;
      end
      S_YELLOW: begin
        yellow_d = own_d;
        red_d    = ~own_d;
      end
      S_ALLRED: red_d = '1;
      S_FLASH: begin
        red_d    = '0;
        yellow_d = phase_d ? '0 : '1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_GREEN;
      dir_q    <= '0;
      timer_q  <= '0;
      phase_q  <= 1'b0;
      green_q  <= ONE;
      yellow_q <= '0;
      red_q    <= ~ONE;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      timer_q  <= timer_d;
      phase_q  <= phase_d;
      green_q  <= green_d;
      yellow_q <= yellow_d;
      red_q    <= red_d;
    end
  end

  assign green   = green_q;
  assign yellow  = yellow_q;
  assign red     = red_q;
  assign cur_dir = dir_q;
  assign state   = state_q;

endmodule
